// File: rtl/screen_sequencer.sv
// screen_sequencer: per-frame title/fade/game/over FSM with source mux and brightness-scaled registered VGA colour.
module screen_sequencer #(
  parameter int unsigned BLINK_FRAMES     = 30,
  parameter int unsigned FADE_STEP_FRAMES = 2,
  parameter int unsigned OVER_FRAMES      = 180
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        vs,
  input  logic        blank,
  input  logic        start_key,
  input  logic        game_over,
  input  logic [11:0] src0_rgb,
  input  logic [11:0] src1_rgb,
  input  logic [11:0] src2_rgb,
  input  logic [11:0] src3_rgb,
  output logic [1:0]  screen_sel,
  output logic        game_active,
  output logic [4:0]  brightness,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);
  typedef enum logic [1:0] {TITLE, FADE, GAME, OVER} state_t;
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] FADE_LAST  = 8'(FADE_STEP_FRAMES - 1);
  localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);
  state_t      state_q;
  logic        vs_q, start_q, phase_q, tick, start_edge;
  logic [7:0]  cnt_q;
  logic [11:0] rgb_sel;
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] b);
    return 4'(({5'd0, c} * {4'd0, b}) >> 4);
  endfunction
  always_comb begin
    tick       = vs_q & ~vs;
    start_edge = start_key & ~start_q;
    rgb_sel    = screen_sel[1] ? (screen_sel[0] ? src3_rgb : src2_rgb)
                               : (screen_sel[0] ? src1_rgb : src0_rgb);
  end
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q     <= TITLE;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      brightness  <= 5'd16;
      screen_sel  <= 2'd0;
      game_active <= 1'b0;
      vs_q        <= 1'b1;
      start_q     <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      vs_q    <= vs;
      start_q <= start_key;
      red     <= blank ? scale(rgb_sel[11:8], brightness) : 4'd0;
      green   <= blank ? scale(rgb_sel[7:4], brightness) : 4'd0;
      blue    <= blank ? scale(rgb_sel[3:0], brightness) : 4'd0;
      case (state_q)
        TITLE:
          // a start press outranks a blink toggle on the same clock
          if (start_edge) begin
            state_q <= FADE;
            cnt_q   <= '0;
          end else if (tick) begin
            if (cnt_q == BLINK_LAST) begin
              cnt_q      <= '0;
              phase_q    <= ~phase_q;
              screen_sel <= {1'b0, ~phase_q};
            end else cnt_q <= cnt_q + 8'd1;
          end
        FADE:
          if (tick) begin
            if (cnt_q == FADE_LAST) begin
              cnt_q <= '0;
              if (brightness == 5'd0) begin
                state_q     <= GAME;
                brightness  <= 5'd16;
                screen_sel  <= 2'd2;
                game_active <= 1'b1;
              end else brightness <= brightness - 5'd1;
            end else cnt_q <= cnt_q + 8'd1;
          end
        GAME:
          if (game_over) begin
            state_q     <= OVER;
            cnt_q       <= '0;
            game_active <= 1'b0;
            screen_sel  <= 2'd3;
          end
        OVER:
          if (tick) begin
            if (cnt_q == OVER_LAST) begin
              state_q    <= TITLE;
              phase_q    <= 1'b0;
              cnt_q      <= '0;
              screen_sel <= 2'd0;
            end else cnt_q <= cnt_q + 8'd1;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: table vectors, hand sequences and random stimulus against a frame-count reference model.
module tb_screen_sequencer;
  localparam int BLINK = 30, FSTEP = 2, OVERF = 180;
  localparam int M_TITLE = 0, M_FADE = 1, M_GAME = 2, M_OVER = 3;
  logic vga_clk = 0, reset, vs, blank, start_key, game_over;
  logic [11:0] src0_rgb, src1_rgb, src2_rgb, src3_rgb;
  logic [1:0] screen_sel;
  logic game_active;
  logic [4:0] brightness;
  logic [3:0] red, green, blue;
  int checks = 0, errors = 0;
  int m_mode, m_ticks, m_title_ticks, m_phase;
  logic m_vs_prev, m_st_prev, m_act;
  logic [1:0] m_sel;
  logic [4:0] m_bright;
  logic [11:0] m_rgb;
  typedef struct {int t; logic [4:0] b; logic [1:0] s; logic a; logic [11:0] rgb;} fade_vec_t;
  typedef struct {logic [4:0] b; logic bl; logic [11:0] src; logic [11:0] rgb;} col_vec_t;
  fade_vec_t fv[8];
  col_vec_t cv[4];

  screen_sequencer #(.BLINK_FRAMES(BLINK), .FADE_STEP_FRAMES(FSTEP), .OVER_FRAMES(OVERF)) dut (
    .vga_clk(vga_clk), .reset(reset), .vs(vs), .blank(blank), .start_key(start_key),
    .game_over(game_over), .src0_rgb(src0_rgb), .src1_rgb(src1_rgb), .src2_rgb(src2_rgb),
    .src3_rgb(src3_rgb), .screen_sel(screen_sel), .game_active(game_active),
    .brightness(brightness), .red(red), .green(green), .blue(blue));

  always #5 vga_clk = ~vga_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] sc(input logic [3:0] c, input logic [4:0] b);
    return 4'((int'(c) * int'(b)) / 16);
  endfunction

  task automatic model_step();
    logic tk, ed;
    logic [11:0] src;
    tk  = m_vs_prev & ~vs;
    ed  = start_key & ~m_st_prev;
    src = (m_sel == 0) ? src0_rgb : (m_sel == 1) ? src1_rgb : (m_sel == 2) ? src2_rgb : src3_rgb;
    if (reset) begin
      m_mode = M_TITLE; m_ticks = 0; m_title_ticks = 0; m_phase = 0;
      m_vs_prev = 1; m_st_prev = 0; m_rgb = 0;
    end else begin
      m_rgb = blank ? {sc(src[11:8], m_bright), sc(src[7:4], m_bright), sc(src[3:0], m_bright)} : 12'h0;
      m_vs_prev = vs;
      m_st_prev = start_key;
      if (m_mode == M_TITLE) begin
        if (ed) begin m_mode = M_FADE; m_ticks = 0; end
        else if (tk) begin m_title_ticks++; m_phase = (m_title_ticks / BLINK) % 2; end
      end else if (m_mode == M_FADE) begin
        if (tk) begin m_ticks++; if (m_ticks == FSTEP * 17) m_mode = M_GAME; end
      end else if (m_mode == M_GAME) begin
        if (game_over) begin m_mode = M_OVER; m_ticks = 0; end
      end else if (tk) begin
        m_ticks++;
        if (m_ticks == OVERF) begin m_mode = M_TITLE; m_title_ticks = 0; m_phase = 0; end
      end
    end
    m_sel    = (m_mode <= M_FADE) ? 2'(m_phase) : 2'(m_mode);
    m_bright = (m_mode == M_FADE) ? 5'(16 - m_ticks / FSTEP) : 5'd16;
    m_act    = (m_mode == M_GAME);
  endtask

  task automatic clk1();
    @(posedge vga_clk);
    model_step();
    #1;
    chk("model_sel", 32'(screen_sel), 32'(m_sel));
    chk("model_active", 32'(game_active), 32'(m_act));
    chk("model_bright", 32'(brightness), 32'(m_bright));
    chk("model_rgb", 32'({red, green, blue}), 32'(m_rgb));
  endtask

  task automatic do_tick();
    vs = 0; clk1();
    vs = 1; clk1();
  endtask

  task automatic press();
    start_key = 1; clk1();
    start_key = 0; clk1();
  endtask

  initial begin
    fv = '{'{0, 5'd16, 2'd0, 1'b0, 12'hF84}, '{1, 5'd16, 2'd0, 1'b0, 12'hF84},
           '{2, 5'd15, 2'd0, 1'b0, 12'hE73}, '{16, 5'd8, 2'd0, 1'b0, 12'h742},
           '{32, 5'd0, 2'd0, 1'b0, 12'h000}, '{33, 5'd0, 2'd0, 1'b0, 12'h000},
           '{34, 5'd16, 2'd2, 1'b1, 12'h5A3}, '{36, 5'd16, 2'd2, 1'b1, 12'h5A3}};
    cv = '{'{5'd16, 1'b1, 12'hF84, 12'hF84}, '{5'd16, 1'b0, 12'hF84, 12'h000},
           '{5'd8, 1'b1, 12'hF84, 12'h742}, '{5'd8, 1'b1, 12'hFFF, 12'h777}};
    reset = 1; vs = 1; blank = 1; start_key = 0; game_over = 0;
    src0_rgb = 12'hF84; src1_rgb = 12'hF84; src2_rgb = 12'h5A3; src3_rgb = 12'h1C9;
    clk1(); clk1();
    chk("reset_sel", 32'(screen_sel), 0);
    chk("reset_bright", 32'(brightness), 16);
    chk("reset_rgb", 32'({red, green, blue}), 0);
    chk("reset_active", 32'(game_active), 0);
    reset = 0;
    clk1();
    // title blink
    for (int t = 1; t <= 65; t++) begin
      do_tick();
      chk("blink_sel", 32'(screen_sel), (t >= 30 && t < 60) ? 1 : 0);
      chk("blink_active", 32'(game_active), 0);
    end
    // fade into game
    press();
    begin
      int cur = 0;
      for (int i = 0; i < 8; i++) begin
        while (cur < fv[i].t) begin do_tick(); cur++; end
        chk("fade_bright", 32'(brightness), 32'(fv[i].b));
        chk("fade_sel", 32'(screen_sel), 32'(fv[i].s));
        chk("fade_active", 32'(game_active), 32'(fv[i].a));
        chk("fade_rgb", 32'({red, green, blue}), 32'(fv[i].rgb));
      end
    end
    // game over hold, start ignored
    game_over = 1; clk1();
    chk("over_sel", 32'(screen_sel), 3);
    chk("over_active", 32'(game_active), 0);
    for (int t = 1; t <= OVERF; t++) begin
      if (t % 20 == 5) press();
      if (t == 100) game_over = 0;
      do_tick();
      if (t == OVERF - 1) chk("over_hold_sel", 32'(screen_sel), 3);
    end
    chk("over_end_sel", 32'(screen_sel), 0);
    chk("over_end_active", 32'(game_active), 0);
    // start edge on the blink-toggle clock, then held start
    for (int t = 1; t <= BLINK - 1; t++) do_tick();
    vs = 0; start_key = 1; clk1();
    chk("coincide_sel", 32'(screen_sel), 0);
    chk("coincide_bright", 32'(brightness), 16);
    vs = 1; clk1();
    for (int t = 0; t < 40; t++) do_tick();
    chk("held_sel", 32'(screen_sel), 2);
    chk("held_active", 32'(game_active), 1);
    chk("held_bright", 32'(brightness), 16);
    start_key = 0;
    reset = 1; clk1();
    chk("game_reset_sel", 32'(screen_sel), 0);
    chk("game_reset_active", 32'(game_active), 0);
    reset = 0; clk1();
    // colour scaling and blanking
    press();
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (brightness !== cv[i].b && n < 60) begin do_tick(); n++; end
      chk("col_bright", 32'(brightness), 32'(cv[i].b));
      src0_rgb = cv[i].src; src1_rgb = cv[i].src; blank = cv[i].bl;
      clk1();
      chk("col_rgb", 32'({red, green, blue}), 32'(cv[i].rgb));
    end
    blank = 1;
    // reset mid-fade
    begin
      int n = 0;
      while (brightness !== 5'd7 && n < 60) begin do_tick(); n++; end
      chk("fade7_bright", 32'(brightness), 7);
    end
    reset = 1; clk1();
    chk("fade_reset_bright", 32'(brightness), 16);
    chk("fade_reset_sel", 32'(screen_sel), 0);
    chk("fade_reset_rgb", 32'({red, green, blue}), 0);
    reset = 0; clk1();
    // random
    for (int c = 0; c < 6000; c++) begin
      vs        = 1'($urandom_range(0, 1));
      start_key = ($urandom_range(0, 7) == 0);
      game_over = ($urandom_range(0, 19) == 0);
      blank     = ($urandom_range(0, 5) != 0);
      reset     = ($urandom_range(0, 1499) == 0);
      src0_rgb  = 12'($urandom); src1_rgb = 12'($urandom);
      src2_rgb  = 12'($urandom); src3_rgb = 12'($urandom);
      clk1();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Top-level display controller that decides which full-screen background reaches the VGA pins.
- Runs a per-frame FSM: blinking title (two alternating start-screen images), fade-out on start key, in-game display, timed game-over hold, then back to title.
- Muxes four 12-bit RGB sources (outputs of the screen mappers) and applies a brightness scale; the result is the final registered VGA colour.

Parameters:
BLINK_FRAMES, 30, frames per title-blink phase (range 1..255)
FADE_STEP_FRAMES, 2, frames per brightness decrement during fade (range 1..255)
OVER_FRAMES, 180, frames the game-over screen is held (range 1..255)

Ports:
vga_clk  input  1  pixel clock; all logic on posedge
reset  input  1  synchronous, active-high
vs  input  1  VGA vsync, active low; frame tick = registered 1->0 transition
blank  input  1  1 = active video (colour allowed), 0 = force black
start_key  input  1  start button level, synchronous to vga_clk
game_over  input  1  level from game logic
src0_rgb  input  12  {r,g,b} from title image A
src1_rgb  input  12  {r,g,b} from title image B
src2_rgb  input  12  {r,g,b} from game renderer
src3_rgb  input  12  {r,g,b} from game-over image
screen_sel  output  2  selected source index (registered)
game_active  output  1  1 while in GAME state
brightness  output  5  current scale 0..16
red, green, blue  output  4 each  final VGA colour

Behaviour:
- Reset:
  - State TITLE, blink_phase 0, frame_cnt 0, brightness 16.
  - screen_sel 0, game_active 0, red/green/blue 0, vs and start_key history registers set to 1 and 0 respectively.
- Frame tick (tick):
  - vs_d <= vs; tick = vs_d & ~vs.
  - One-cycle pulse per frame.
- Start edge (start_edge):
  - start_edge = start_key & ~start_key_d, evaluated every clock, not only on tick.
- TITLE:
  - screen_sel = blink_phase (0 or 1).
  - On tick: frame_cnt++; when frame_cnt reaches BLINK_FRAMES-1, frame_cnt <= 0 and blink_phase toggles.
  - start_edge -> FADE, frame_cnt <= 0, blink_phase frozen.
  - If start_edge and a blink toggle coincide, start_edge wins: phase does not toggle.
- FADE:
  - screen_sel holds the frozen blink_phase.
  - On tick: frame_cnt++; when frame_cnt reaches FADE_STEP_FRAMES-1, frame_cnt <= 0 and brightness decrements.
  - When brightness is 0 and the step condition fires -> GAME, brightness <= 16, frame_cnt <= 0.
  - Brightness never wraps below 0.
  - start_key and game_over are ignored.
- GAME:
  - screen_sel 2, game_active 1.
  - game_over sampled every clock; game_over=1 -> OVER, frame_cnt <= 0, game_active <= 0 the same edge.
- OVER:
  - screen_sel 3.
  - On tick: frame_cnt++; when frame_cnt reaches OVER_FRAMES-1 -> TITLE, blink_phase <= 0, frame_cnt <= 0.
  - start_key ignored; a held game_over does not re-trigger anything.
- screen_sel, game_active and brightness are registered and update on the same edge as the state change.
- Colour path:
  - Source selection uses the registered screen_sel value.
  - Per channel: scaled = (c * brightness) >> 4, computed as 4b x 5b = 9b, then truncated to 4 bits.
  - brightness 16 gives identity (15*16>>4 = 15); brightness 0 gives black.
  - red/green/blue <= blank ? scaled : 0.
  - Latency: 1 vga_clk from src*_rgb/blank to the pins.
- Reset asserted mid-fade or mid-game: next edge returns to the full reset state, and outputs are black for that cycle.

Test Plan:
1. Reset, then 65 ticks with no keys -> screen_sel 0 for ticks 1-29, 1 for ticks 30-59, 0 from tick 60; game_active 0.
2. In TITLE, pulse start_key for 1 clock -> next edge state FADE; brightness 16->15 after tick 2 and reaches 0 after tick 32; at tick 34 screen_sel=2, brightness=16, game_active=1.
3. Colour scaling: src0_rgb=12'hF84, blank=1. At brightness 16 the output is F/8/4; at 8 it is 7/4/2; at 0 it is 0/0/0. Lowering blank forces 0 one clock later.
4. In GAME, raise game_over -> screen_sel=3, game_active=0 on the next edge. Pressing start_key during OVER has no effect. After 180 ticks screen_sel=0 and blink_phase=0.
5. start_key edge on the exact clock of a blink toggle (frame_cnt=29, tick=1) -> FADE entered, screen_sel unchanged (no toggle). start_key held high for many frames -> only one FADE entry.
6. Assert reset during FADE at brightness 7 -> next edge: brightness 16, screen_sel 0, RGB 0, TITLE state.
